// File: rtl/direct_dma_pkg.sv
// ============================================================================
//  Module   : direct_dma_pkg
//  Purpose  : Shared definitions for the block-mode descriptor responder:
//             descriptor field offsets, status bit positions, accept FSM
//             state encoding and the descriptor / status struct types.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package direct_dma_pkg;

    // Raw descriptor and status widths
    localparam int DESC_W          = 256;
    localparam int STATUS_W        = 160;

    // Descriptor field positions inside desc_data
    localparam int DESC_IRQ_BIT    = 0;
    localparam int DESC_FIRST_BIT  = 10;
    localparam int DESC_LAST_BIT   = 11;
    localparam int DESC_BCOUNT_LSB = 32;
    localparam int DESC_BCOUNT_W   = 32;
    localparam int DESC_SYS_LSB    = 64;
    localparam int DESC_CARD_LSB   = 128;
    localparam int DESC_ADDR_W     = 64;

    // Completion status bit positions
    localparam int ST_IRQ          = 0;
    localparam int ST_FIRST        = 1;
    localparam int ST_LAST         = 2;
    localparam int ST_ERROR        = 3;
    localparam int ST_SHORT        = 4;
    localparam int ST_ABORTED      = 5;
    localparam int ST_PROTO_ERR    = 6;
    localparam int ST_BCOUNT_LSB   = 32;
    localparam int ST_ADDR_LSB     = 64;
    localparam int ST_SEQ_LSB      = 128;

    // Accept handshake states
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACK      = 2'd1,
        ST_WAIT_LOW = 2'd2
    } acc_state_t;

    // Descriptor as held in the ring (chain_err is resolved at accept time)
    typedef struct packed {
        logic [DESC_ADDR_W-1:0]   card_addr;
        logic [DESC_ADDR_W-1:0]   sys_addr;
        logic [DESC_BCOUNT_W-1:0] bcount;
        logic                     last;
        logic                     first;
        logic                     irq;
        logic                     chain_err;
    } desc_t;

    // Completion status word, MSB first
    typedef struct packed {
        logic [31:0] seq;
        logic [63:0] end_addr;
        logic [31:0] cpl_bcount;
        logic [24:0] rsvd;
        logic        proto_err;
        logic        aborted;
        logic        short_xfer;
        logic        error;
        logic        last;
        logic        first;
        logic        irq;
    } status_t;

endpackage

`default_nettype wire

// File: rtl/direct_desc_ring.sv
// ============================================================================
//  Module   : direct_desc_ring
//  Purpose  : Descriptor ring storage with write, dispatch and completion
//             pointers (each carrying a wrap bit) plus occupancy flags.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module direct_desc_ring
    import direct_dma_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  i_clr,
    input  logic  i_push,
    input  desc_t i_push_entry,
    input  logic  i_disp_adv,
    input  logic  i_cpl_adv,
    input  logic  i_trunc,
    output logic  o_full,
    output logic  o_empty,
    output logic  o_pending,
    output logic  o_outstanding,
    output desc_t o_disp_entry,
    output desc_t o_cpl_entry
);

    localparam int                 c_IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                 c_PTR_W   = c_IDX_W + 1;
    localparam logic [c_PTR_W-1:0] c_ONE     = c_PTR_W'(1);
    localparam logic [c_PTR_W-1:0] c_DEPTH_P = c_PTR_W'(DEPTH);

    desc_t              r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr;
    logic [c_PTR_W-1:0] r_disp;
    logic [c_PTR_W-1:0] r_cpl;
    logic [c_PTR_W-1:0] w_occ;

    // Descriptor storage; contents need no reset, pointers qualify them
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr[c_IDX_W-1:0]] <= i_push_entry;
        end
    end

    // Pointer update; truncation discards everything not yet dispatched
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr   <= '0;
            r_disp <= '0;
            r_cpl  <= '0;
        end else if (i_clr) begin
            r_wr   <= '0;
            r_disp <= '0;
            r_cpl  <= '0;
        end else begin
            if (i_trunc) begin
                r_wr <= r_disp;
            end else if (i_push) begin
                r_wr <= r_wr + c_ONE;
            end
            if (i_disp_adv) begin
                r_disp <= r_disp + c_ONE;
            end
            if (i_cpl_adv) begin
                r_cpl <= r_cpl + c_ONE;
            end
        end
    end

    assign w_occ         = r_wr - r_cpl;
    assign o_full        = (w_occ == c_DEPTH_P);
    assign o_empty       = (r_wr == r_cpl);
    assign o_pending     = (r_disp != r_wr);
    assign o_outstanding = (r_cpl != r_disp);
    assign o_disp_entry  = r_mem[r_disp[c_IDX_W-1:0]];
    assign o_cpl_entry   = r_mem[r_cpl[c_IDX_W-1:0]];

endmodule

`default_nettype wire

// File: rtl/direct_desc_responder.sv
// ============================================================================
//  Module   : direct_desc_responder
//  Purpose  : Block-mode DMA descriptor responder: 4-phase accept handshake,
//             in-order dispatch to the transfer engine, completion status
//             generation with a one-entry skid, abort and soft reset.
//  Options  : DIRECT_DESC_CHAIN_CHECK_EN enables first/last chain checking.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module direct_desc_responder
    import direct_dma_pkg::*;
#(
    parameter int         DESC_DEPTH = 4,
    parameter logic [7:0] CHANNEL    = 8'd0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                desc_rst_n,
    input  logic                desc_req,
    input  logic [31:0]         desc_ptr,
    input  logic [DESC_W-1:0]   desc_data,
    output logic                desc_ready,
    input  logic                desc_abort,
    output logic                desc_abort_ack,
    output logic                desc_done,
    output logic [7:0]          desc_done_channel,
    output logic [STATUS_W-1:0] desc_done_status,
    output logic                xfer_valid,
    input  logic                xfer_ready,
    output logic [63:0]         xfer_sys_addr,
    output logic [63:0]         xfer_card_addr,
    output logic [31:0]         xfer_bcount,
    output logic                xfer_first,
    output logic                xfer_last,
    input  logic                xfer_cpl_valid,
    input  logic [31:0]         xfer_cpl_bcount,
    input  logic                xfer_cpl_error
);

    acc_state_t  r_state;
    acc_state_t  w_state_nxt;
    logic        w_push;
    desc_t       w_desc_in;
    desc_t       w_push_entry;
    desc_t       w_disp_entry;
    desc_t       w_cpl_entry;
    logic        w_chain_err;
    logic        w_full;
    logic        w_empty;
    logic        w_pending;
    logic        w_outstanding;
    logic        w_xfer_valid;
    logic        w_disp_zero;
    logic        w_fire;
    logic        w_block;
    logic        w_zb;
    logic        w_cpl_ok;
    logic        w_evt;
    logic        w_proto;
    logic        w_trunc;
    logic [31:0] w_cpl_bytes;
    status_t     w_new_status;
    status_t     r_status;
    status_t     r_skid;
    logic        r_skid_valid;
    logic        r_done;
    logic        r_proto_err;
    logic        r_abort_ack;
    logic [31:0] r_seq;
    logic        w_unused;

    // Pointer-only and reserved descriptor bits carry nothing in block mode
    assign w_unused = ^{desc_ptr, desc_data[255:192], desc_data[31:12],
                        desc_data[9:1], w_empty};

    // Field extraction from the raw descriptor word
    always_comb begin
        w_desc_in           = '0;
        w_desc_in.card_addr = desc_data[DESC_CARD_LSB +: DESC_ADDR_W];
        w_desc_in.sys_addr  = desc_data[DESC_SYS_LSB +: DESC_ADDR_W];
        w_desc_in.bcount    = desc_data[DESC_BCOUNT_LSB +: DESC_BCOUNT_W];
        w_desc_in.last      = desc_data[DESC_LAST_BIT];
        w_desc_in.first     = desc_data[DESC_FIRST_BIT];
        w_desc_in.irq       = desc_data[DESC_IRQ_BIT];
        w_desc_in.chain_err = 1'b0;
        w_push_entry           = w_desc_in;
        w_push_entry.chain_err = w_chain_err;
    end

`ifdef DIRECT_DESC_CHAIN_CHECK_EN
    logic r_in_chain;

    // A chain is open after any accepted descriptor without last set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_chain <= 1'b0;
        end else if (!desc_rst_n) begin
            r_in_chain <= 1'b0;
        end else if (w_push) begin
            r_in_chain <= !w_desc_in.last;
        end
    end

    assign w_chain_err = (w_desc_in.first && r_in_chain) ||
                         (!w_desc_in.first && !r_in_chain);
`else
    assign w_chain_err = 1'b0;
`endif

    // Accept FSM state register; a soft reset seen with desc_req still high
    // parks in WAIT_LOW so the stale level is not taken as a new descriptor
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else if (!desc_rst_n) begin
            r_state <= desc_req ? ST_WAIT_LOW : ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Accept FSM next state and capture strobe
    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (desc_req && !w_full && !desc_abort && desc_rst_n) begin
                    w_push      = 1'b1;
                    w_state_nxt = ST_ACK;
                end
            end
            ST_ACK: begin
                if (!desc_req) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT_LOW: begin
                if (!desc_req) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign desc_ready = (r_state == ST_ACK);

    direct_desc_ring #(
        .DEPTH (DESC_DEPTH)
    ) u_ring (
        .clk           (clk),
        .rst           (rst),
        .i_clr         (!desc_rst_n),
        .i_push        (w_push),
        .i_push_entry  (w_push_entry),
        .i_disp_adv    (w_fire || w_zb),
        .i_cpl_adv     (w_evt),
        .i_trunc       (w_trunc),
        .o_full        (w_full),
        .o_empty       (w_empty),
        .o_pending     (w_pending),
        .o_outstanding (w_outstanding),
        .o_disp_entry  (w_disp_entry),
        .o_cpl_entry   (w_cpl_entry)
    );

    // Dispatch: zero-length entries never reach the engine; they retire in
    // place once everything ahead of them has completed (cpl == disp)
    assign w_disp_zero  = (w_disp_entry.bcount == '0);
    assign w_xfer_valid = w_pending && !desc_abort && !w_disp_zero;
    assign w_fire       = w_xfer_valid && xfer_ready;

    // Skid occupied and done still high: no room for another retire
    assign w_block   = r_skid_valid && r_done;
    assign w_zb      = w_pending && w_disp_zero && !w_outstanding &&
                       !desc_abort && !w_block;
    assign w_cpl_ok  = xfer_cpl_valid && w_outstanding && !w_block;
    assign w_proto   = xfer_cpl_valid && !w_cpl_ok;
    assign w_evt     = w_cpl_ok || w_zb;
    assign w_trunc   = desc_abort && !w_outstanding;

    assign w_cpl_bytes = w_zb ? 32'd0 : xfer_cpl_bcount;

    // Status word for the entry retiring this cycle
    always_comb begin
        w_new_status                              = '0;
        w_new_status[ST_IRQ]                      = w_cpl_entry.irq;
        w_new_status[ST_FIRST]                    = w_cpl_entry.first;
        w_new_status[ST_LAST]                     = w_cpl_entry.last;
        w_new_status[ST_ERROR]                    = w_zb || w_cpl_entry.chain_err ||
                                                    (w_cpl_ok && xfer_cpl_error);
        w_new_status[ST_SHORT]                    = (w_cpl_bytes < w_cpl_entry.bcount);
        w_new_status[ST_ABORTED]                  = desc_abort;
        w_new_status[ST_PROTO_ERR]                = r_proto_err;
        w_new_status[ST_BCOUNT_LSB +: 32]         = w_cpl_bytes;
        w_new_status[ST_ADDR_LSB +: DESC_ADDR_W]  = w_cpl_entry.sys_addr + {32'd0, w_cpl_bytes};
        w_new_status[ST_SEQ_LSB +: 32]            = r_seq;
    end

    // Done pulse generation with a one-entry skid to keep pulses 2 cycles apart
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done       <= 1'b0;
            r_status     <= '0;
            r_skid       <= '0;
            r_skid_valid <= 1'b0;
            r_proto_err  <= 1'b0;
            r_seq        <= '0;
        end else if (!desc_rst_n) begin
            r_done       <= 1'b0;
            r_status     <= '0;
            r_skid       <= '0;
            r_skid_valid <= 1'b0;
            r_proto_err  <= 1'b0;
            r_seq        <= '0;
        end else begin
            if (w_proto) begin
                r_proto_err <= 1'b1;
            end
            if (w_evt) begin
                r_seq <= r_seq + 32'd1;
            end
            if (r_done) begin
                r_done <= 1'b0;
                if (w_evt) begin
                    r_skid       <= w_new_status;
                    r_skid_valid <= 1'b1;
                end
            end else if (r_skid_valid) begin
                r_done       <= 1'b1;
                r_status     <= r_skid;
                r_skid_valid <= w_evt;
                if (w_evt) begin
                    r_skid <= w_new_status;
                end
            end else if (w_evt) begin
                r_done   <= 1'b1;
                r_status <= w_new_status;
            end
        end
    end

    // Abort acknowledge: raised once nothing is outstanding, held until abort drops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_abort_ack <= 1'b0;
        end else if (!desc_rst_n) begin
            r_abort_ack <= 1'b0;
        end else begin
            r_abort_ack <= desc_abort && (r_abort_ack || !w_outstanding);
        end
    end

    assign desc_abort_ack    = r_abort_ack;
    assign desc_done         = r_done;
    assign desc_done_channel = CHANNEL;
    assign desc_done_status  = r_status;

    assign xfer_valid     = w_xfer_valid;
    assign xfer_sys_addr  = w_xfer_valid ? w_disp_entry.sys_addr  : 64'd0;
    assign xfer_card_addr = w_xfer_valid ? w_disp_entry.card_addr : 64'd0;
    assign xfer_bcount    = w_xfer_valid ? w_disp_entry.bcount    : 32'd0;
    assign xfer_first     = w_xfer_valid && w_disp_entry.first;
    assign xfer_last      = w_xfer_valid && w_disp_entry.last;

endmodule

`default_nettype wire

// File: tb/tb_direct_desc_responder.sv
// ============================================================================
//  Module   : tb_direct_desc_responder
//  Purpose  : Directed self-checking bench for direct_desc_responder.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_direct_desc_responder;

    logic         clk = 1'b0;
    logic         rst;
    logic         desc_rst_n;
    logic         desc_req;
    logic [31:0]  desc_ptr;
    logic [255:0] desc_data;
    logic         desc_ready;
    logic         desc_abort;
    logic         desc_abort_ack;
    logic         desc_done;
    logic [7:0]   desc_done_channel;
    logic [159:0] desc_done_status;
    logic         xfer_valid;
    logic         xfer_ready;
    logic [63:0]  xfer_sys_addr;
    logic [63:0]  xfer_card_addr;
    logic [31:0]  xfer_bcount;
    logic         xfer_first;
    logic         xfer_last;
    logic         xfer_cpl_valid;
    logic [31:0]  xfer_cpl_bcount;
    logic         xfer_cpl_error;

    int checks = 0;
    int errors = 0;

    direct_desc_responder #(
        .DESC_DEPTH (4),
        .CHANNEL    (8'h5A)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .desc_rst_n        (desc_rst_n),
        .desc_req          (desc_req),
        .desc_ptr          (desc_ptr),
        .desc_data         (desc_data),
        .desc_ready        (desc_ready),
        .desc_abort        (desc_abort),
        .desc_abort_ack    (desc_abort_ack),
        .desc_done         (desc_done),
        .desc_done_channel (desc_done_channel),
        .desc_done_status  (desc_done_status),
        .xfer_valid        (xfer_valid),
        .xfer_ready        (xfer_ready),
        .xfer_sys_addr     (xfer_sys_addr),
        .xfer_card_addr    (xfer_card_addr),
        .xfer_bcount       (xfer_bcount),
        .xfer_first        (xfer_first),
        .xfer_last         (xfer_last),
        .xfer_cpl_valid    (xfer_cpl_valid),
        .xfer_cpl_bcount   (xfer_cpl_bcount),
        .xfer_cpl_error    (xfer_cpl_error)
    );

    always #5 clk = ~clk;

    // ---------------- stimulus helpers (no checking of results) ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        desc_rst_n      = 1'b1;
        desc_req        = 1'b0;
        desc_ptr        = 32'hDEAD_BEEF;
        desc_data       = '0;
        desc_abort      = 1'b0;
        xfer_ready      = 1'b0;
        xfer_cpl_valid  = 1'b0;
        xfer_cpl_bcount = '0;
        xfer_cpl_error  = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic send_desc(input logic [63:0] sys, input logic [63:0] card,
                             input logic [31:0] bc, input logic f, input logic l,
                             input logic irq);
        int n;
        desc_data = {64'd0, card, sys, bc, 20'd0, l, f, 9'd0, irq};
        desc_req  = 1'b1;
        n = 0;
        while (!desc_ready && n < 40) begin
            tick();
            n++;
        end
        if (!desc_ready) begin
            checks++;
            errors++;
            $display("FAIL send_ready_timeout got ready=%0b want 1", desc_ready);
        end
        desc_req = 1'b0;
        tick();
    endtask

    task automatic dispatch(input int n);
        int fired;
        int guard;
        fired = 0;
        guard = 0;
        xfer_ready = 1'b1;
        while (fired < n && guard < 40) begin
            if (xfer_valid) fired++;
            tick();
            guard++;
        end
        xfer_ready = 1'b0;
        if (fired != n) begin
            checks++;
            errors++;
            $display("FAIL dispatch_timeout got %0d want %0d", fired, n);
        end
    endtask

    task automatic complete(input logic [31:0] bc, input logic err);
        xfer_cpl_valid  = 1'b1;
        xfer_cpl_bcount = bc;
        xfer_cpl_error  = err;
        tick();
        xfer_cpl_valid  = 1'b0;
        xfer_cpl_error  = 1'b0;
    endtask

    task automatic wait_done(input int max, output bit got, output logic [159:0] st);
        got = 1'b0;
        st  = '0;
        for (int i = 0; i < max; i++) begin
            if (desc_done) begin
                got = 1'b1;
                st  = desc_done_status;
                break;
            end
            tick();
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        checks++;
        if ({desc_ready, desc_done, desc_abort_ack, xfer_valid} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctl got %b want 0000",
                     {desc_ready, desc_done, desc_abort_ack, xfer_valid});
        end
        checks++;
        if (desc_done_status !== 160'd0 || xfer_sys_addr !== 64'd0 || xfer_bcount !== 32'd0) begin
            errors++;
            $display("FAIL reset_data got status=%h addr=%h bc=%h want 0",
                     desc_done_status, xfer_sys_addr, xfer_bcount);
        end
        checks++;
        if (desc_done_channel !== 8'h5A) begin
            errors++;
            $display("FAIL reset_channel got %h want 5a", desc_done_channel);
        end
    endtask

    task automatic test_single();
        bit           got;
        logic [159:0] st;
        do_reset();
        send_desc(64'h1000, 64'h0, 32'h200, 1'b1, 1'b1, 1'b0);
        checks++;
        if (xfer_valid !== 1'b1 || xfer_sys_addr !== 64'h1000 || xfer_card_addr !== 64'h0 ||
            xfer_bcount !== 32'h200 || xfer_first !== 1'b1 || xfer_last !== 1'b1) begin
            errors++;
            $display("FAIL single_xfer got v=%b sys=%h card=%h bc=%h f=%b l=%b want 1 1000 0 200 1 1",
                     xfer_valid, xfer_sys_addr, xfer_card_addr, xfer_bcount, xfer_first, xfer_last);
        end
        dispatch(1);
        checks++;
        if (xfer_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_disp_clear got %b want 0", xfer_valid);
        end
        complete(32'h200, 1'b0);
        wait_done(5, got, st);
        checks++;
        if (!got || st[63:32] !== 32'h200 || st[127:64] !== 64'h1200 || st[2:1] !== 2'b11 ||
            st[4:3] !== 2'b00 || st[159:128] !== 32'd0) begin
            errors++;
            $display("FAIL single_status got done=%b status=%h want bc=200 addr=1200 fl=11 seq=0",
                     got, st);
        end
        tick();
        checks++;
        if (desc_done !== 1'b0) begin
            errors++;
            $display("FAIL single_pulse got %b want 0", desc_done);
        end
    endtask

    task automatic test_full();
        int hold_bad;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send_desc(64'h1000 * (i + 1), 64'h0, 32'h40, 1'b1, 1'b1, 1'b0);
        end
        desc_data = {64'd0, 64'h0, 64'h9000, 32'h40, 20'd0, 1'b1, 1'b1, 9'd0, 1'b0};
        desc_req  = 1'b1;
        hold_bad  = 0;
        for (int i = 0; i < 6; i++) begin
            if (desc_ready) hold_bad++;
            tick();
        end
        checks++;
        if (hold_bad != 0) begin
            errors++;
            $display("FAIL full_hold got %0d ready cycles want 0", hold_bad);
        end
        dispatch(1);
        xfer_cpl_valid  = 1'b1;
        xfer_cpl_bcount = 32'h40;
        tick();
        xfer_cpl_valid  = 1'b0;
        checks++;
        if (desc_ready !== 1'b0 || desc_done !== 1'b1) begin
            errors++;
            $display("FAIL full_same_cycle got ready=%b done=%b want 0 1", desc_ready, desc_done);
        end
        tick();
        checks++;
        if (desc_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_accept got %b want 1", desc_ready);
        end
        desc_req = 1'b0;
        tick();
    endtask

    task automatic test_abort();
        bit           got;
        logic [159:0] st;
        int           n_done;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send_desc(64'hA000 + 64'(i * 'h100), 64'h0, 32'h100, 1'b1, 1'b1, 1'b0);
        end
        dispatch(1);
        desc_abort = 1'b1;
        tick();
        checks++;
        if (xfer_valid !== 1'b0 || desc_abort_ack !== 1'b0) begin
            errors++;
            $display("FAIL abort_stop got v=%b ack=%b want 0 0", xfer_valid, desc_abort_ack);
        end
        complete(32'h100, 1'b0);
        wait_done(3, got, st);
        checks++;
        if (!got || st[5] !== 1'b1 || st[63:32] !== 32'h100 || st[127:64] !== 64'hA100) begin
            errors++;
            $display("FAIL abort_done got done=%b status=%h want aborted=1 bc=100 addr=a100", got, st);
        end
        n_done = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (desc_done) n_done++;
        end
        checks++;
        if (n_done != 0 || desc_abort_ack !== 1'b1) begin
            errors++;
            $display("FAIL abort_discard got extra_done=%0d ack=%b want 0 1", n_done, desc_abort_ack);
        end
        desc_abort = 1'b0;
        tick();
        checks++;
        if (desc_abort_ack !== 1'b0 || xfer_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_release got ack=%b v=%b want 0 0", desc_abort_ack, xfer_valid);
        end
    endtask

    task automatic test_error();
        bit           got;
        logic [159:0] st;
        do_reset();
        send_desc(64'h2000, 64'h40, 32'h100, 1'b1, 1'b1, 1'b1);
        dispatch(1);
        complete(32'h80, 1'b1);
        wait_done(5, got, st);
        checks++;
        if (!got || st[4:3] !== 2'b11 || st[63:32] !== 32'h80 || st[127:64] !== 64'h2080 ||
            st[0] !== 1'b1) begin
            errors++;
            $display("FAIL error_status got done=%b status=%h want short=1 err=1 bc=80 addr=2080 irq=1",
                     got, st);
        end
    endtask

    task automatic test_soft_reset();
        bit           got;
        logic [159:0] st;
        int           bad;
        do_reset();
        send_desc(64'h3000, 64'h0, 32'h40, 1'b1, 1'b1, 1'b0);
        dispatch(1);
        complete(32'h40, 1'b0);
        wait_done(5, got, st);
        tick();
        send_desc(64'h4000, 64'h0, 32'h40, 1'b1, 1'b0, 1'b0);
        dispatch(1);
        send_desc(64'h5000, 64'h0, 32'h40, 1'b0, 1'b1, 1'b0);
        desc_rst_n = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (desc_ready || desc_done || desc_abort_ack || xfer_valid ||
                (|desc_done_status) || (|xfer_sys_addr) || (|xfer_bcount)) bad++;
        end
        checks++;
        if (bad != 0 || desc_done_channel !== 8'h5A) begin
            errors++;
            $display("FAIL soft_rst_outputs got %0d nonzero cycles ch=%h want 0 5a", bad, desc_done_channel);
        end
        desc_rst_n = 1'b1;
        tick();
        send_desc(64'h6000, 64'h0, 32'h80, 1'b1, 1'b1, 1'b0);
        checks++;
        if (xfer_valid !== 1'b1 || xfer_sys_addr !== 64'h6000) begin
            errors++;
            $display("FAIL soft_rst_accept got v=%b sys=%h want 1 6000", xfer_valid, xfer_sys_addr);
        end
        dispatch(1);
        complete(32'h80, 1'b0);
        wait_done(5, got, st);
        checks++;
        if (!got || st[159:128] !== 32'd0 || st[63:32] !== 32'h80 || st[3] !== 1'b0) begin
            errors++;
            $display("FAIL soft_rst_seq got done=%b status=%h want seq=0 bc=80 err=0", got, st);
        end
    endtask

    task automatic test_zero_bcount();
        bit           got;
        logic [159:0] st;
        do_reset();
        send_desc(64'h7000, 64'h0, 32'h0, 1'b1, 1'b1, 1'b1);
        wait_done(1, got, st);
        checks++;
        if (!got || st[3] !== 1'b1 || st[4] !== 1'b0 || st[63:32] !== 32'd0 ||
            st[127:64] !== 64'h7000 || st[0] !== 1'b1) begin
            errors++;
            $display("FAIL zero_bc_status got done=%b status=%h want err=1 short=0 bc=0 addr=7000 irq=1",
                     got, st);
        end
        tick();
        checks++;
        if (xfer_valid !== 1'b0 || desc_done !== 1'b0) begin
            errors++;
            $display("FAIL zero_bc_idle got v=%b done=%b want 0 0", xfer_valid, desc_done);
        end
    endtask

    task automatic test_back_to_back();
        bit           got;
        logic [159:0] st;
        logic [159:0] s1;
        logic [159:0] s3;
        logic [3:0]   pat;
        int           n_done;
        do_reset();
        send_desc(64'hB000, 64'h0, 32'h10, 1'b1, 1'b1, 1'b0);
        send_desc(64'hC000, 64'h0, 32'h20, 1'b1, 1'b1, 1'b0);
        send_desc(64'hD000, 64'h0, 32'h30, 1'b1, 1'b1, 1'b0);
        dispatch(3);
        xfer_cpl_valid  = 1'b1;
        xfer_cpl_bcount = 32'h10;
        tick();
        pat[3] = desc_done;
        s1     = desc_done_status;
        xfer_cpl_bcount = 32'h20;
        tick();
        pat[2] = desc_done;
        xfer_cpl_valid = 1'b0;
        tick();
        pat[1] = desc_done;
        s3     = desc_done_status;
        tick();
        pat[0] = desc_done;
        checks++;
        if (pat !== 4'b1010) begin
            errors++;
            $display("FAIL b2b_spacing got %b want 1010", pat);
        end
        checks++;
        if (s1[63:32] !== 32'h10 || s3[63:32] !== 32'h20 || s3[159:128] !== 32'd1 ||
            s3[127:64] !== 64'hC020) begin
            errors++;
            $display("FAIL b2b_status got s1bc=%h s3bc=%h s3seq=%h s3addr=%h want 10 20 1 c020",
                     s1[63:32], s3[63:32], s3[159:128], s3[127:64]);
        end
        complete(32'h30, 1'b0);
        wait_done(5, got, st);
        checks++;
        if (!got || st[159:128] !== 32'd2 || st[6] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_third got done=%b status=%h want seq=2 proto=0", got, st);
        end
        tick();
        complete(32'h55, 1'b0);
        n_done = 0;
        for (int i = 0; i < 3; i++) begin
            if (desc_done) n_done++;
            tick();
        end
        checks++;
        if (n_done != 0) begin
            errors++;
            $display("FAIL proto_ignored got %0d dones want 0", n_done);
        end
        send_desc(64'hE000, 64'h0, 32'h10, 1'b1, 1'b1, 1'b0);
        dispatch(1);
        complete(32'h10, 1'b0);
        wait_done(5, got, st);
        checks++;
        if (!got || st[6] !== 1'b1 || st[159:128] !== 32'd3) begin
            errors++;
            $display("FAIL proto_sticky got done=%b status=%h want proto=1 seq=3", got, st);
        end
    endtask

    task automatic test_chain();
        bit           got;
        logic [159:0] sa;
        logic [159:0] sb;
        logic         exp_err;
`ifdef DIRECT_DESC_CHAIN_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        do_reset();
        send_desc(64'hF000, 64'h0, 32'h10, 1'b1, 1'b0, 1'b0);
        send_desc(64'hF100, 64'h0, 32'h10, 1'b1, 1'b0, 1'b0);
        dispatch(2);
        complete(32'h10, 1'b0);
        wait_done(5, got, sa);
        tick();
        complete(32'h10, 1'b0);
        wait_done(5, got, sb);
        checks++;
        if (!got || sa[3] !== 1'b0 || sb[3] !== exp_err || sb[2:1] !== 2'b01) begin
            errors++;
            $display("FAIL chain_check got done=%b err_a=%b err_b=%b fl_b=%b want 1 0 %b 01",
                     got, sa[3], sb[3], sb[2:1], exp_err);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_full();
        test_abort();
        test_error();
        test_soft_reset();
        test_zero_bcount();
        test_back_to_back();
        test_chain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/direct_desc_responder.md
# direct_desc_responder

Target-side responder for the direct (block-mode) DMA descriptor interface. It accepts 256-bit block-mode descriptors over the 4-phase `desc_req`/`desc_ready` handshake and buffers them in a small ring. It dispatches them in order to the transfer datapath and reports each completion on `desc_done` with a 160-bit status. It sits between the descriptor source (software BFM or hardware sequencer) and the S2C/C2S transfer engine, one instance per engine.

## Interface
- `DESC_DEPTH`, 4: ring entries; power of two, 2..16.
- `CHANNEL`, 8'd0: constant driven on `desc_done_channel`.
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `desc_rst_n` in 1: synchronous soft reset, active-low.
- `desc_req` in 1: descriptor request; level, held until `desc_ready` is seen.
- `desc_ptr` in 32: ignored in block mode.
- `desc_data` in 256: {64'b0, card_addr[191:128], sys_addr[127:64], bcount[63:32], 20'b0, last[11], first[10], 9'b0, irq[0]}.
- `desc_ready` out 1: acceptance acknowledge.
- `desc_abort` in 1: abort request, level.
- `desc_abort_ack` out 1: abort complete, level.
- `desc_done` out 1: one-cycle completion pulse.
- `desc_done_channel` out 8: `CHANNEL`.
- `desc_done_status` out 160: completion status, valid while `desc_done` is high.
- `xfer_valid` / `xfer_ready` out / in 1: dispatch handshake; the transfer fires when both are high on a clock edge.
- `xfer_sys_addr`, `xfer_card_addr` out 64; `xfer_bcount` out 32; `xfer_first`, `xfer_last` out 1.
- `xfer_cpl_valid` in 1; `xfer_cpl_bcount` in 32; `xfer_cpl_error` in 1: in-order completions from the datapath.

## Operation
**Ring**
- Three pointers, each with an extra wrap bit: `wr`, `disp`, `cpl`.
- Occupancy = `wr − cpl`. Full when occupancy equals `DESC_DEPTH`.

**Accept FSM**
- States: IDLE, ACK, WAIT_LOW.
- IDLE: if `desc_req`=1, ring not full, and not aborting, then capture `desc_data` at `wr`, increment `wr`, go to ACK.
- ACK: `desc_ready`=1. Stay while `desc_req`=1. When `desc_req`=0, go to IDLE and drop `desc_ready` on the same edge.
- If the ring is full, `desc_req` waits in IDLE with `desc_ready`=0.

**Dispatch**
- `xfer_valid`=1 while `disp≠wr` and not aborting. Fields come from entry `disp`.
- Handshake increments `disp`.
- A descriptor with bcount=0 is never dispatched. It is retired directly when it reaches `cpl`, with error bit set and byte count 0.

**Completion**
- Each `xfer_cpl_valid` retires entry `cpl` and increments `cpl`.
- A `xfer_cpl_valid` while `cpl==disp` is a protocol error: ignored, sticky `proto_err` status bit set.

**Status layout**
- [0] = irq
- [1] = first
- [2] = last
- [3] = error (`xfer_cpl_error`, zero bcount, chain error)
- [4] = short (cpl_bcount < bcount)
- [5] = aborted
- [6] = proto_err
- [31:7] = 0
- [63:32] = cpl_bcount
- [127:64] = sys_addr + cpl_bcount (64-bit wrap)
- [159:128] = running descriptor sequence number (32-bit wrap, cleared by reset)

**Abort**
- While `desc_abort`=1: stop accepting and dispatching.
- Undispatched entries (`disp..wr`) are discarded, with no done.
- Outstanding entries complete normally and carry aborted=1.
- When `cpl==disp`, set `wr=disp` and assert `desc_abort_ack`. Hold it until `desc_abort`=0, then clear it on the next edge.

**Soft reset**
- `desc_rst_n`=0 synchronously clears the pointers, FSM, sequence number, sticky bits and outputs.
- Completions still in flight are dropped.

## Timing
- Reset values: all outputs 0 except `desc_done_channel`=`CHANNEL`.
- `desc_ready` rises 1 cycle after `desc_req` is sampled high with space available. It falls 1 cycle after `desc_req` is sampled low.
- Accept-to-`xfer_valid`: 1 cycle (registered pointer).
- `xfer_cpl_valid` to `desc_done`: 1 cycle, registered.
- Zero-bcount retire: `desc_done` 1 cycle after the entry becomes head with `cpl==disp`.
- Minimum `desc_done` spacing: 2 cycles. Completions arriving back-to-back are held in a 1-entry skid buffer.
  - `xfer_cpl_valid` while the skid is full is a protocol error.
- Simultaneous accept and retire at full: retire frees the slot only on the following cycle (no same-cycle bypass).
- Reset mid-handshake: `desc_ready` returns low. The source must re-present the descriptor.

## Configuration
- `DIRECT_DESC_CHAIN_CHECK_EN` defined:
  - Track the in-chain state.
  - first=1 while in-chain, or first=0 while idle, sets error bit [3] on that descriptor's status.
  - The descriptor is still dispatched.
- Undefined: no chain tracking; first/last are passed through only.

## Structure
- Package `direct_dma_pkg` holds:
  - Descriptor field offsets/widths.
  - Status bit positions.
  - The descriptor struct typedef and the status struct typedef.
- One sub-module, `direct_desc_ring`: storage plus the three pointers, with full/empty/pending flags.
- Top level holds the accept FSM, dispatch, completion skid, abort and chain check.

## Test plan
- Single descriptor, sys 0x1000, card 0x0, bcount 0x200, first=last=1:
  - `xfer_*` carries these values.
  - After cpl 0x200: status[63:32]=0x200, [127:64]=0x1200, [2:1]=2'b11.
- Five descriptors back-to-back with `DESC_DEPTH`=4 and `xfer_ready`=0:
  - Fifth `desc_req` sees `desc_ready` low until the first completion, plus 1 cycle.
- Abort with 1 descriptor dispatched and 2 queued:
  - One done with aborted=1; no done for the other two.
  - `desc_abort_ack` high until `desc_abort` drops.
- Completion 0x80 on bcount 0x100 with `xfer_cpl_error`=1: status[4]=1, [3]=1, [63:32]=0x80.
- `desc_rst_n` low for 10 cycles mid-chain: all outputs 0, sequence restarts at 0, next accept normal.
- With `DIRECT_DESC_CHAIN_CHECK_EN`, two first=1 descriptors without last: second status[3]=1.
